// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// The CHK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  // Frame start marker
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  // Instruction field widths, shared with the instruction decoder
  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned OPERAND_W = 11;

  typedef enum logic [2:0] {
    StIdle,
    StLenH,
    StLenL,
    StDataH,
    StDataL,
`ifdef LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } loader_state_t;

  // Big-endian byte pair to instruction word {opcode, operand}
  function automatic logic [OPCODE_W+OPERAND_W-1:0] pack_word(input logic [7:0] hi,
                                                              input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// 8-bit running XOR accumulator with synchronous clear and enable.
// Used by program_loader only when LOADER_CHECKSUM_EN is defined.
module loader_xor_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q;

  // Clear has priority; otherwise fold in each enabled byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: decodes a UART byte-stream frame (sync, 16-bit word count,
// big-endian words) into program memory writes and holds the CPU in reset
// until a frame completes cleanly.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_rst_n,
  output logic               load_done,
  output logic               load_err
);

  // Word count needs one extra bit so a full-depth image is representable
  localparam int unsigned CntW = ADDR_W + 1;

  loader_state_t state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [CntW-1:0]    len_q, len_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         hi_q, hi_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;

  logic [15:0] len_full;
  logic        len_bad;
  logic        is_sync;

  assign len_full = {len_hi_q, rx_data};
  assign len_bad  = (len_full == 16'd0) || ({16'd0, len_full} > (32'd1 << ADDR_W));
  assign is_sync  = (rx_data == SYNC_BYTE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       xor_clr;
  logic       xor_en;

  // Restart the checksum at every accepted sync; fold every length and data byte
  assign xor_clr = rx_valid && is_sync &&
                   (state_q == StIdle || state_q == StDone || state_q == StErr);
  assign xor_en  = rx_valid &&
                   (state_q == StLenH || state_q == StLenL ||
                    state_q == StDataH || state_q == StDataL);

  loader_xor_acc u_xor_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xor_clr),
    .en    (xor_en),
    .din   (rx_data),
    .acc   (xor_acc)
  );
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Frame decoder: next state and write-register contents per accepted byte
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (rx_valid) begin
      unique case (state_q)
        // Only a sync byte starts a frame here; anything else is dropped
        StIdle, StDone, StErr: begin
          if (is_sync) begin
            state_d = StLenH;
            addr_d  = '0;
            cnt_d   = '0;
          end
        end
        StLenH: begin
          len_hi_d = rx_data;
          state_d  = StLenL;
        end
        StLenL: begin
          if (len_bad) begin
            state_d = StErr;
          end else begin
            len_d   = CntW'(len_full);
            state_d = StDataH;
          end
        end
        StDataH: begin
          hi_d    = rx_data;
          state_d = StDataL;
        end
        StDataL: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = INSTR_W'(pack_word(hi_q, rx_data));
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q + CntW'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataH;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          state_d = (rx_data == xor_acc) ? StDone : StErr;
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;

  // CPU runs only after a clean frame; a new sync drops it back into reset
  assign cpu_rst_n = (state_q == StDone);
  assign load_done = (state_q == StDone);
  assign load_err  = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_program_loader;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct {int cyc; logic [10:0] addr; logic [15:0] data;} exp_t;
  typedef struct {int idx; logic [10:0] addr; logic [15:0] data;} mw_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_rst_n;
  logic               load_done;
  logic               load_err;

  program_loader #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [15:0] tmem [DEPTH];

  // Model results for the frame currently being sent
  mw_t m_wr[$];
  int  m_sync;
  int  m_out;   // 0 = incomplete/none, 1 = done, 2 = error

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr,
                 mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
      tmem[mem_addr] = mem_wdata;
    end
  end

  // Reference model: reads the frame as a byte list by position
  task automatic model(input bq_t b);
    int i;
    int n;
    logic [7:0] x;
    m_wr.delete();
    m_out  = 0;
    m_sync = -1;
    i = -1;
    for (int k = 0; k < b.size(); k++) begin
      if (i < 0 && b[k] == 8'h55) i = k;
    end
    if (i < 0) return;
    m_sync = i;
    if (b.size() < i + 3) return;
    n = int'(b[i+1]) * 256 + int'(b[i+2]);
    if (n == 0 || n > DEPTH) begin
      m_out = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (i + 4 + 2 * w < b.size())
        m_wr.push_back('{idx: i + 4 + 2 * w, addr: 11'(w), data: {b[i+3+2*w], b[i+4+2*w]}});
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    if (i + 3 + 2 * n < b.size()) begin
      for (int k = i + 1; k <= i + 2 + 2 * n; k++) x = x ^ b[k];
      m_out = (x == b[i+3+2*n]) ? 1 : 2;
    end
`else
    x = 8'h00;
    if (i + 2 + 2 * n < b.size()) m_out = 1 + int'(x);
`endif
  endtask

  // Send one byte after 'gap' idle cycles; returns at the negedge after capture
  task automatic drive(input logic [7:0] b, input int gap, input bit push, input mw_t w);
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    if (push) sb.push_back('{cyc: cyc + 1, addr: w.addr, data: w.data});
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input string tag, input bq_t f, input int gap_max);
    int wi;
    model(f);
    wi = 0;
    for (int i = 0; i < f.size(); i++) begin
      mw_t w;
      bit  p;
      w = '{idx: 0, addr: '0, data: '0};
      p = 1'b0;
      if (wi < m_wr.size() && m_wr[wi].idx == i) begin
        w = m_wr[wi];
        p = 1'b1;
        wi++;
      end
      drive(f[i], $urandom_range(gap_max, 0), p, w);
      if (i == m_sync) begin
        check({tag, "_sync_done"}, 32'(load_done), 0);
        check({tag, "_sync_err"}, 32'(load_err), 0);
        check({tag, "_sync_cpu"}, 32'(cpu_rst_n), 0);
      end
    end
    check({tag, "_done"}, 32'(load_done), 32'(m_out == 1));
    check({tag, "_err"}, 32'(load_err), 32'(m_out == 2));
    check({tag, "_cpu"}, 32'(cpu_rst_n), 32'(m_out == 1));
    repeat (2) @(negedge clk);
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic make_frame(input int n, input bit bad_ck, output bq_t f);
    logic [7:0] x;
    logic [7:0] v;
    f = {};
    f.push_back(8'h55);
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    if (n == 0 || n > DEPTH) return;
    for (int k = 0; k < 2 * n; k++) begin
      v = 8'($urandom);
      f.push_back(v);
      x = x ^ v;
    end
`ifdef LOADER_CHECKSUM_EN
    f.push_back(bad_ck ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
`else
    if (bad_ck) x = 8'h00;
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_cpu"}, 32'(cpu_rst_n), 0);
    check({tag, "_done"}, 32'(load_done), 0);
    check({tag, "_err"}, 32'(load_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    mw_t nw;
    nw = '{idx: 0, addr: '0, data: '0};

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_rel");

    send_frame("noise", '{8'h00, 8'hFF, 8'h12}, 1);

`ifdef LOADER_CHECKSUM_EN
    f = '{8'h55, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10, 8'h05, 8'h1E};
`else
    f = '{8'h55, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10, 8'h05};
`endif
    send_frame("basic", f, 2);
    check("basic_w0", 32'(tmem[0]), 32'h0801);
    check("basic_w1", 32'(tmem[1]), 32'h1005);
    send_frame("b2b", f, 0);

    send_frame("len0", '{8'h55, 8'h00, 8'h00}, 1);
    send_frame("len2049", '{8'h55, 8'h08, 8'h01}, 1);

`ifdef LOADER_CHECKSUM_EN
    send_frame("badck", '{8'h55, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10, 8'h05, 8'h00}, 1);
    send_frame("goodck", f, 1);
`endif

    // Abort mid-frame, then a fresh frame must start at address 0
    drive(8'h55, 0, 1'b0, nw);
    drive(8'h00, 0, 1'b0, nw);
    drive(8'h03, 1, 1'b0, nw);
    drive(8'h08, 0, 1'b0, nw);
    #2 rst_n = 1'b0;
    #2 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame("after_rst", f, 1);

    make_frame(DEPTH, 1'b0, f);
    send_frame("full_depth", f, 0);

    for (int it = 0; it < 24; it++) begin
      int n;
      int kind;
      int pre;
      bq_t g;
      kind = $urandom_range(9, 0);
      if (kind == 0) n = 0;
      else if (kind == 1) n = $urandom_range(65535, DEPTH + 1);
      else n = $urandom_range(8, 1);
      make_frame(n, ($urandom_range(3, 0) == 0), f);
      g = {};
      pre = $urandom_range(2, 0);
      for (int k = 0; k < pre; k++) begin
        logic [7:0] v;
        v = 8'($urandom);
        if (v == 8'h55) v = 8'h56;
        g.push_back(v);
      end
      g = {g, f};
      send_frame("rand", g, $urandom_range(2, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image, received as a byte stream from the board UART receiver, into the CPU program memory, and holds the CPU in reset while it does so. It fills program memory, which the control block's program counter later reads. The loader decodes one frame: sync byte, 16-bit word count, then big-endian instruction words. Each word is a 5-bit opcode followed by an 11-bit operand. When the frame completes cleanly, the loader releases the CPU reset.

## Interface
- ADDR_W, 11, program memory address width; depth is 2^ADDR_W words
- INSTR_W, 16, instruction word width; fixed at two bytes
- SYNC_BYTE, 8'h55, frame start marker
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle; back-to-back strobes are allowed
- mem_we  out  1  program memory write enable, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  INSTR_W  write data: {opcode[4:0], operand[10:0]}
- cpu_rst_n  out  1  CPU reset; low while loading or in error
- load_done  out  1  high after a successful load, until the next sync byte
- load_err  out  1  high after a rejected frame, until the next sync byte

## Operation
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK (present only when the checksum feature is compiled in), DONE, ERR.
- IDLE:
  - A byte equal to SYNC_BYTE moves to LEN_H and clears the word address.
  - Any other byte is discarded.
- LEN_H, LEN_L: capture the word count N.
  - N = 0 → ERR.
  - N > 2^ADDR_W → ERR.
- DATA_H: latch the high byte, then go to DATA_L.
- DATA_L: form the word {high, low} and register the write.
  - The address counter increments after each write.
  - After word N: go to CHK if the feature is present, otherwise DONE.
- DONE: cpu_rst_n = 1, load_done = 1.
- ERR: cpu_rst_n = 0, load_err = 1.
- Restart from DONE or ERR:
  - A byte equal to SYNC_BYTE clears load_done and load_err.
  - cpu_rst_n goes low in the same cycle the flags clear.
  - The state moves to LEN_H and a new load begins.
  - Other bytes are ignored.
- Sync inside a frame: a byte equal to SYNC_BYTE during the LEN or DATA states is ordinary data, not a resync.
- Address wrap: cannot occur, because N is bounded by the depth.
- Word arithmetic:
  - mem_addr counts 0..N-1.
  - N is held in ADDR_W+1 bits.
  - A word counter is compared against N.

## Timing
- Reset values: mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_rst_n = 0, load_done = 0, load_err = 0, state = IDLE.
- mem_we, mem_addr and mem_wdata are registered. mem_we pulses in the cycle after the rx_valid that carried the low byte.
- Back-to-back rx_valid is supported:
  - The write register is independent of byte capture.
  - No byte is dropped.
- cpu_rst_n and load_done rise in the cycle after the final accepted byte, which is the last low byte or the checksum byte.
- load_err rises in the cycle after the offending byte.
- Reset asserted mid-frame aborts the load immediately:
  - Everything returns to reset values.
  - Any in-flight write is cancelled; memory contents already written stay as they are.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A trailing byte follows the last data word. It must equal the XOR of every byte from LEN_H through the last data byte.
  - Match → DONE. Mismatch → ERR, and the CPU stays in reset.
  - Words already written remain in memory.
- LOADER_CHECKSUM_EN undefined: the CHK state and the XOR accumulator are absent, and the last data word goes straight to DONE.

## Structure
- Shared package loader_pkg holds:
  - the state enum loader_state_t;
  - SYNC_BYTE;
  - OPCODE_W = 5 and OPERAND_W = 11, shared with the instruction decoder.
- One sub-module: loader_xor_acc, an 8-bit running XOR with clear and enable. It is instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Idle noise: bytes 0x00, 0xFF, 0x12 with no sync → no mem_we pulses, cpu_rst_n stays 0, both flags stay 0.
- Basic load: 55 00 02 08 01 10 05 (+ checksum 0x1E if enabled) → writes addr 0 = 0x0801 and addr 1 = 0x1005; cpu_rst_n = 1 and load_done = 1 one cycle after the final byte.
- Bad length:
  - 55 00 00 → load_err = 1, cpu_rst_n = 0, no writes.
  - 55 08 01 (N = 2049) → same response.
- Back-to-back strobes: the basic-load frame driven with rx_valid high on consecutive cycles → both writes occur, each one cycle after its low byte.
- Checksum mismatch (macro on): basic-load frame with checksum 0x00 → load_err = 1, cpu_rst_n = 0; resending the correct frame → load_done = 1.
- Reset mid-frame: assert rst_n low after 55 00 03 08 → all outputs return to reset values; a new frame then loads correctly starting at addr 0.
